// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master control engine: runs byte transfers requested by the control register.
// Optional macro SPI_LOOPBACK_EN: shift-in path samples internal MOSI instead of miso_i.
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned ADDR_W  = 9
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic [31:0]       ctrl_i,
   output logic [31:0]       ctrl_o,
   output logic              ctrl_wr_o,
   output logic [ADDR_W-1:0] tx_addr_o,
   input  logic [7:0]        tx_data_i,
   output logic [ADDR_W-1:0] rx_addr_o,
   output logic [7:0]        rx_data_o,
   output logic              rx_we_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic              cs_n_o,
   output logic              busy_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE, S_WAIT} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_idx, w_idx_nxt;
   logic [ADDR_W-1:0] r_n_end, w_n_end_nxt;
   logic              r_all1, w_all1_nxt;
   logic              r_all0, w_all0_nxt;
   logic [DIV_W-1:0]  r_div, w_div_nxt;
   logic [3:0]        r_ph, w_ph_nxt;
   logic [7:0]        r_tx, w_tx_nxt;
   logic [7:0]        r_rx, w_rx_nxt;
   logic              r_sclk, w_sclk_nxt;
   logic              r_mosi, w_mosi_nxt;
   logic              r_cs_n, w_cs_n_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_ctrl_wr, w_ctrl_wr_nxt;
   logic [31:0]       r_ctrl, w_ctrl_nxt;
   logic              r_rx_we, w_rx_we_nxt;
   logic [ADDR_W-1:0] r_rx_addr, w_rx_addr_nxt;
   logic [7:0]        r_rx_data, w_rx_data_nxt;
   logic [ADDR_W-1:0] r_tx_addr, w_tx_addr_nxt;

   logic [7:0]        w_tx_byte;
   logic              w_mosi_bit;
   logic              w_in_bit;

   // ALL_1S has priority over ALL_0S
   assign w_tx_byte  = r_all1 ? 8'hFF : (r_all0 ? 8'h00 : tx_data_i);
   // bit on the wire this cycle; first SHIFT cycle still carries the freshly read byte
   assign w_mosi_bit = (r_ph == 4'd0 && r_div == '0) ? w_tx_byte[7] : r_mosi;

`ifdef SPI_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = miso_i;
   assign w_in_bit      = w_mosi_bit;
`else
   assign w_in_bit      = miso_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_n_end   <= '0;
         r_all1    <= 1'b0;
         r_all0    <= 1'b0;
         r_div     <= '0;
         r_ph      <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_ctrl_wr <= 1'b0;
         r_ctrl    <= '0;
         r_rx_we   <= 1'b0;
         r_rx_addr <= '0;
         r_rx_data <= '0;
         r_tx_addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_n_end   <= w_n_end_nxt;
         r_all1    <= w_all1_nxt;
         r_all0    <= w_all0_nxt;
         r_div     <= w_div_nxt;
         r_ph      <= w_ph_nxt;
         r_tx      <= w_tx_nxt;
         r_rx      <= w_rx_nxt;
         r_sclk    <= w_sclk_nxt;
         r_mosi    <= w_mosi_nxt;
         r_cs_n    <= w_cs_n_nxt;
         r_busy    <= w_busy_nxt;
         r_ctrl_wr <= w_ctrl_wr_nxt;
         r_ctrl    <= w_ctrl_nxt;
         r_rx_we   <= w_rx_we_nxt;
         r_rx_addr <= w_rx_addr_nxt;
         r_rx_data <= w_rx_data_nxt;
         r_tx_addr <= w_tx_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_n_end_nxt   = r_n_end;
      w_all1_nxt    = r_all1;
      w_all0_nxt    = r_all0;
      w_div_nxt     = r_div;
      w_ph_nxt      = r_ph;
      w_tx_nxt      = r_tx;
      w_rx_nxt      = r_rx;
      w_mosi_nxt    = r_mosi;
      w_ctrl_wr_nxt = 1'b0;
      w_ctrl_nxt    = r_ctrl;
      w_rx_we_nxt   = 1'b0;
      w_rx_addr_nxt = r_rx_addr;
      w_rx_data_nxt = r_rx_data;
      w_tx_addr_nxt = r_tx_addr;

      case (r_state)
         S_IDLE: begin
            w_idx_nxt = '0;
            if (ctrl_i[0]) begin
               w_n_end_nxt   = ADDR_W'(ctrl_i[12:4]);
               w_all1_nxt    = ctrl_i[2];
               w_all0_nxt    = ctrl_i[3];
               w_tx_addr_nxt = '0;
               w_state_nxt   = S_LOAD;
            end
         end
         S_LOAD: begin
            w_div_nxt   = '0;
            w_ph_nxt    = '0;
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_ph == 4'd0 && r_div == '0) begin
               w_tx_nxt   = w_tx_byte;
               w_mosi_nxt = w_tx_byte[7];
            end
            // even phases are SCLK low, odd phases SCLK high
            if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               if (!r_ph[0]) begin
                  w_rx_nxt = {r_rx[6:0], w_in_bit};
               end else if (r_ph != 4'd15) begin
                  w_tx_nxt   = {r_tx[6:0], 1'b0};
                  w_mosi_nxt = r_tx[6];
               end
               if (r_ph == 4'd15) begin
                  w_rx_we_nxt   = 1'b1;
                  w_rx_addr_nxt = r_idx;
                  w_rx_data_nxt = r_rx;
                  w_ctrl_wr_nxt = 1'b1;
                  w_ctrl_nxt    = {ctrl_i[31:26], 10'(r_idx) + 10'd1, ctrl_i[15:0]};
                  w_state_nxt   = S_STORE;
               end else begin
                  w_ph_nxt = r_ph + 4'd1;
               end
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
         end
         S_STORE: begin
            if (r_idx == r_n_end) begin
               w_ctrl_wr_nxt = 1'b1;
               w_ctrl_nxt    = {ctrl_i[31:26], 10'(r_n_end) + 10'd1, ctrl_i[15:1], 1'b0};
               w_state_nxt   = S_DONE;
            end else begin
               w_idx_nxt     = r_idx + ADDR_W'(1);
               w_tx_addr_nxt = r_idx + ADDR_W'(1);
               w_state_nxt   = S_LOAD;
            end
         end
         S_DONE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_sclk_nxt = (w_state_nxt == S_SHIFT) ? w_ph_nxt[0] : 1'b0;
      w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_WAIT);
      case (w_state_nxt)
         S_LOAD, S_SHIFT, S_STORE, S_DONE: w_cs_n_nxt = 1'b0;
         S_IDLE:                           w_cs_n_nxt = ~ctrl_i[1];
         default:                          w_cs_n_nxt = 1'b1;
      endcase
   end

   assign ctrl_o    = r_ctrl;
   assign ctrl_wr_o = r_ctrl_wr;
   assign tx_addr_o = r_tx_addr;
   assign rx_addr_o = r_rx_addr;
   assign rx_data_o = r_rx_data;
   assign rx_we_o   = r_rx_we;
   assign sclk_o    = r_sclk;
   assign mosi_o    = r_mosi;
   assign cs_n_o    = r_cs_n;
   assign busy_o    = r_busy;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Control engine on the register side of the SPI peripheral.
- Reads the 32-bit SPI control register, runs the requested byte transfers as an SPI mode-0 master, and stores received bytes in the RX buffer.
- Writes status back to the control register over its high-priority write port (data/strobe pair).
- Sits between the control register, the TX/RX byte buffers and the SPI pins.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk_i cycles (SCLK = f_clk/(2*CLK_DIV)); legal range >=1.
- ADDR_W, 9, buffer address width; max 2^ADDR_W bytes per transaction.

Ports:
- clk_i  in  1  system clock (10 MHz).
- rst  in  1  reset; synchronous, active-low.
- ctrl_i  in  32  current control register value.
- ctrl_o  out  32  write-back value for the control register.
- ctrl_wr_o  out  1  write-back strobe (priority port).
- tx_addr_o  out  ADDR_W  TX buffer read address; synchronous read, 1-cycle latency.
- tx_data_i  in  8  TX buffer read data.
- rx_addr_o  out  ADDR_W  RX buffer write address.
- rx_data_o  out  8  RX buffer write data.
- rx_we_o  out  1  RX buffer write enable.
- sclk_o  out  1  SPI clock; CPOL=0.
- mosi_o  out  1  master out.
- miso_i  in  1  master in.
- cs_n_o  out  1  chip select, active-low.
- busy_o  out  1  transaction in progress.

Behaviour:
Control register fields:
- [0] SEND.
- [1] CS_HOLD.
- [2] ALL_1S.
- [3] ALL_0S.
- [12:4] N_TX_END: byte count minus 1.
- [25:16] N_RX: bytes received.
- All other bits are preserved on write-back.

Reset (rst=0, takes effect on the next clk_i edge, also mid-transfer):
- State returns to IDLE.
- sclk_o=0, mosi_o=0, cs_n_o=1, busy_o=0.
- ctrl_wr_o=0, rx_we_o=0, tx_addr_o=0, rx_addr_o=0, rx_data_o=0, ctrl_o=0.
- No write-back occurs for an aborted transfer.

State machine:
- IDLE:
  - Byte index idx=0.
  - SEND=1 → latch N_TX_END, ALL_1S and ALL_0S; go to LOAD; busy_o=1.
  - Field changes during a transfer are ignored.
- LOAD: tx_addr_o=idx; wait 1 cycle for read data; go to SHIFT.
- SHIFT:
  - TX byte is ALL_1S ? 8'hFF : ALL_0S ? 8'h00 : tx_data_i. ALL_1S wins when both flags are set.
  - MSB first.
  - mosi_o changes while sclk_o is low; miso_i is sampled on the rising sclk_o edge.
  - Each phase lasts CLK_DIV cycles; 8 full SCLK periods per byte.
  - sclk_o ends low.
- STORE (1 cycle):
  - rx_we_o=1, rx_addr_o=idx, rx_data_o=received byte.
  - ctrl_wr_o=1, with ctrl_o=ctrl_i except N_RX=idx+1.
- STORE exit:
  - idx==N_TX_END → DONE.
  - Otherwise idx increments → LOAD.
- DONE:
  - ctrl_wr_o=1, with ctrl_o=ctrl_i except SEND=0 and N_RX=N_TX_END+1.
  - Go to WAIT.
- WAIT: 1 cycle so the cleared SEND becomes visible; busy_o=0; return to IDLE. SEND is not re-sampled here.

Chip select:
- cs_n_o=0 from LOAD entry until DONE exit.
- If CS_HOLD=1 (live value), cs_n_o=0 also in IDLE.

Boundaries and timing:
- N_TX_END=0 transfers exactly 1 byte.
- N_TX_END=2^ADDR_W−1 transfers the full buffer; idx must not wrap before DONE.
- ctrl_wr_o pulses exactly once per byte plus once at DONE, each 1 cycle wide.
- Per-byte latency: 1 (LOAD) + 16*CLK_DIV (SHIFT) + 1 (STORE) cycles.
- N_RX is zero-extended to 10 bits.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the shift-in path samples the internal MOSI value instead of miso_i, so RX data equals TX data; miso_i is ignored.
- Undefined: miso_i is sampled normally.

Test Plan:
- Single byte: ctrl_i SEND=1, N_TX_END=0, tx buffer[0]=8'hA5, CLK_DIV=2 → mosi_o bit sequence 1,0,1,0,0,1,0,1.
  - ctrl_wr_o pulses 2 times, final ctrl_o[0]=0, N_RX=1.
  - cs_n_o low for 1+32+1+1 cycles.
- 3-byte burst, miso_i sourced from a slave model returning 8'h3C,8'hC3,8'h5A → rx_we_o 3 times at addresses 0,1,2 with those bytes.
  - Intermediate ctrl_o N_RX = 1, 2; final 3 with SEND=0.
- ALL_1S=1 and ALL_0S=1, buffer contents 8'h00, N_TX_END=1 → mosi_o held 1 for 16 bits; TX buffer data ignored.
- CS_HOLD=1 while IDLE → cs_n_o=0 with no SCLK activity.
  - Clearing CS_HOLD in IDLE → cs_n_o=1 next cycle.
- rst=0 pulsed during bit 4 of byte 2 → next cycle: IDLE, sclk_o=0, cs_n_o=1, busy_o=0; no further ctrl_wr_o or rx_we_o.
- SPI_LOOPBACK_EN defined, N_TX_END=1, TX bytes 8'h81,8'h7E, miso_i held 0 → RX buffer receives 8'h81,8'h7E.
